// File: rtl/seq_detect_scheduler_if.sv
// Requester/match bundle for seq_detect_scheduler. Counter readout signals
// exist only when MATCH_CNT_EN is defined.
interface seq_detect_scheduler_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_bit;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] chan_clr;
    logic           match_valid;
    logic [CHW-1:0] match_ch;
`ifdef MATCH_CNT_EN
    logic [CHW-1:0] cnt_sel;
    logic [CW-1:0]  cnt_out;
`endif

    modport master (
        output req_valid, req_bit, chan_clr,
`ifdef MATCH_CNT_EN
        output cnt_sel,
        input  cnt_out,
`endif
        input  req_ready, match_valid, match_ch
    );

    modport slave (
        input  req_valid, req_bit, chan_clr,
`ifdef MATCH_CNT_EN
        input  cnt_sel,
        output cnt_out,
`endif
        output req_ready, match_valid, match_ch
    );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin time-shared 1101 (overlapping) Mealy detector over NCH serial channels.
// Optional per-channel saturating match counters enabled by MATCH_CNT_EN.
//
// state | meaning
// S0    | nothing useful seen
// S1    | suffix "1"
// S2    | suffix "11"
// S3    | suffix "110" (a following 1 is a match)
module seq_detect_scheduler #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detect_scheduler_if.slave bus
);
    localparam int CHW = $clog2(NCH);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_e;

    det_state_e     state_q [NCH];
    det_state_e     state_d [NCH];
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic           match_valid_q, match_valid_d;
    logic [CHW-1:0] match_ch_q, match_ch_d;

    logic [NCH-1:0] grant;
    logic           grant_any;
    logic [CHW-1:0] grant_idx;
    logic [CHW-1:0] scan_idx;
    det_state_e     cur_state;
    logic           cur_bit;
    logic           hit;

    function automatic det_state_e det_next(input det_state_e s, input logic x);
        det_state_e n;
        n = S0;
        unique case (s)
            S0: n = x ? S1 : S0;
            S1: n = x ? S2 : S0;
            S2: n = x ? S2 : S3;
            S3: n = x ? S1 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    // Scan from rr_ptr upward; NCH is a power of two so the index wraps naturally.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = rr_ptr_q + CHW'(k);
            if (!reset && !grant_any && bus.req_valid[scan_idx] && !bus.chan_clr[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    assign bus.req_ready = grant;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = bus.chan_clr[i] ? S0 : state_q[i];
        end
        rr_ptr_d      = rr_ptr_q;
        match_valid_d = 1'b0;
        match_ch_d    = match_ch_q;
        cur_state     = state_q[grant_idx];
        cur_bit       = bus.req_bit[grant_idx];
        hit           = 1'b0;
        if (grant_any) begin
            state_d[grant_idx] = det_next(cur_state, cur_bit);
            hit                = (cur_state == S3) && cur_bit;
            rr_ptr_d           = grant_idx + CHW'(1);
        end
        if (hit) begin
            match_valid_d = 1'b1;
            match_ch_d    = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S0;
            end
            rr_ptr_q      <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign bus.match_valid = match_valid_q;
    assign bus.match_ch    = match_ch_q;

`ifdef MATCH_CNT_EN
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.chan_clr[i]) begin
                cnt_d[i] = '0;
            end else if (hit && (grant_idx == CHW'(i)) && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.cnt_out = cnt_q[bus.cnt_sel];
`endif
endmodule
